// File: rtl/machine_csr_file.sv
// Machine-mode CSR file: Zicsr read-modify-write access, 64-bit counters,
// memory-mapped mtime/mtimecmp timer, and trap-entry/mret bookkeeping.
module machine_csr_file #(
    parameter int unsigned         XLEN      = 32,
    parameter int unsigned         HART_ID   = 0,
    parameter logic [XLEN-1:0]     RESET_VEC = 32'h0000_0000,
    parameter int unsigned         MTIME_DIV = 1,
    parameter logic [XLEN-1:0]     MISA_VAL  = 32'h4000_0100
) (
    input  logic            clk,
    input  logic            resetn,
    input  logic            csr_valid,
    input  logic [1:0]      csr_op,
    input  logic [11:0]     csr_addr,
    input  logic [XLEN-1:0] csr_wdata,
    output logic [XLEN-1:0] csr_rdata,
    output logic            csr_illegal,
    input  logic            instret_pulse,
    input  logic            trap_valid,
    input  logic [XLEN-1:0] trap_cause,
    input  logic [XLEN-1:0] trap_pc,
    input  logic [XLEN-1:0] trap_tval,
    input  logic            mret,
    input  logic            tmr_wr,
    input  logic [1:0]      tmr_sel,
    input  logic [XLEN-1:0] tmr_wdata,
    output logic [XLEN-1:0] tmr_rdata,
    output logic [XLEN-1:0] trap_vector,
    output logic [XLEN-1:0] mepc_out,
    output logic            irq_timer
);

    localparam logic [1:0] OP_RW = 2'b01;
    localparam logic [1:0] OP_RS = 2'b10;
    localparam logic [1:0] OP_RC = 2'b11;

    localparam int unsigned PW = (MTIME_DIV > 1) ? $clog2(MTIME_DIV) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(MTIME_DIV - 1);

    logic            mstatus_mie;
    logic            mstatus_mpie;
    logic            mie_mtie;
    logic [XLEN-1:0] mtvec;
    logic [XLEN-1:0] mscratch;
    logic [XLEN-1:0] mepc;
    logic [XLEN-1:0] mcause;
    logic [XLEN-1:0] mtval;
    logic [63:0]     mcycle;
    logic [63:0]     minstret;
    logic [63:0]     mtime;
    logic [63:0]     mtimecmp;
    logic [PW-1:0]   prescaler;

    logic            mtip;
    logic            implemented;
    logic            wr_intent;
    logic            csr_we;
    logic [XLEN-1:0] old_val;
    logic [XLEN-1:0] new_val;
    logic [XLEN-1:0] mstatus_rd;

    logic            mtime_tick;
    logic [63:0]     mcycle_inc,   mcycle_nxt;
    logic [63:0]     minstret_inc, minstret_nxt;
    logic [63:0]     mtime_inc,    mtime_nxt;

    assign mtip = (mtime >= mtimecmp);

    always_comb begin
        mstatus_rd        = '0;
        mstatus_rd[12:11] = 2'b11;
        mstatus_rd[7]     = mstatus_mpie;
        mstatus_rd[3]     = mstatus_mie;
    end

    // NOTE: every output of a combinational block gets a default first, so
    // no path through the case leaves a signal unassigned and infers a latch.
    always_comb begin
        old_val     = '0;
        implemented = 1'b1;
        case (csr_addr)
            12'hF11, 12'hF12, 12'hF13: old_val = '0;
            12'hF14: old_val = XLEN'(HART_ID);
            12'h301: old_val = MISA_VAL;
            12'h300: old_val = mstatus_rd;
            12'h304: old_val = {24'b0, mie_mtie, 7'b0};
            12'h305: old_val = mtvec;
            12'h340: old_val = mscratch;
            12'h341: old_val = mepc;
            12'h342: old_val = mcause;
            12'h343: old_val = mtval;
            12'h344: old_val = {24'b0, mtip, 7'b0};
            12'hB00, 12'hC00: old_val = mcycle[31:0];
            12'hB80, 12'hC80: old_val = mcycle[63:32];
            12'hB02, 12'hC02: old_val = minstret[31:0];
            12'hB82, 12'hC82: old_val = minstret[63:32];
            12'hC01: old_val = mtime[31:0];
            12'hC81: old_val = mtime[63:32];
            default: implemented = 1'b0;
        endcase
    end

    // Set/clear with a zero operand is a pure read, so it may touch read-only CSRs.
    assign wr_intent   = (csr_op == OP_RW) ||
                         ((csr_op == OP_RS || csr_op == OP_RC) && csr_wdata != '0);
    assign csr_illegal = csr_valid && (!implemented ||
                         (csr_addr[11:10] == 2'b11 && wr_intent));
    assign csr_we      = csr_valid && wr_intent && !csr_illegal;
    assign csr_rdata   = csr_illegal ? '0 : old_val;

    always_comb begin
        case (csr_op)
            OP_RW:   new_val = csr_wdata;
            OP_RS:   new_val = old_val | csr_wdata;
            OP_RC:   new_val = old_val & ~csr_wdata;
            default: new_val = old_val;
        endcase
    end

    assign mtime_tick = (prescaler == PRESC_MAX);

    // A half written this cycle takes the written value; writing the low half
    // suppresses the carry into the high half for that cycle.
    always_comb begin
        mcycle_inc   = mcycle + 64'd1;
        mcycle_nxt   = mcycle_inc;
        if (csr_we && csr_addr == 12'hB00)
            mcycle_nxt = {mcycle[63:32], new_val};
        else if (csr_we && csr_addr == 12'hB80)
            mcycle_nxt = {new_val, mcycle_inc[31:0]};

        minstret_inc = minstret + {63'b0, instret_pulse};
        minstret_nxt = minstret_inc;
        if (csr_we && csr_addr == 12'hB02)
            minstret_nxt = {minstret[63:32], new_val};
        else if (csr_we && csr_addr == 12'hB82)
            minstret_nxt = {new_val, minstret_inc[31:0]};

        mtime_inc    = mtime + {63'b0, mtime_tick};
        mtime_nxt    = mtime_inc;
        if (tmr_wr && tmr_sel == 2'd0)
            mtime_nxt = {mtime[63:32], tmr_wdata};
        else if (tmr_wr && tmr_sel == 2'd1)
            mtime_nxt = {tmr_wdata, mtime_inc[31:0]};
    end

    // NOTE: all state uses non-blocking assignments so every register samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        // NOTE: reset is sampled on the clock edge only; resetn is not in the
        // sensitivity list, so it must be held low across at least one edge.
        if (!resetn) begin
            mstatus_mie  <= 1'b0;
            mstatus_mpie <= 1'b0;
            mie_mtie     <= 1'b0;
            mtvec        <= RESET_VEC;
            mscratch     <= '0;
            mepc         <= '0;
            mcause       <= '0;
            mtval        <= '0;
            mcycle       <= '0;
            minstret     <= '0;
            mtime        <= '0;
            mtimecmp     <= '1;
            prescaler    <= '0;
        end else begin
            mcycle    <= mcycle_nxt;
            minstret  <= minstret_nxt;
            mtime     <= mtime_nxt;
            prescaler <= mtime_tick ? '0 : prescaler + PW'(1);

            if (tmr_wr && tmr_sel == 2'd2) mtimecmp[31:0]  <= tmr_wdata;
            if (tmr_wr && tmr_sel == 2'd3) mtimecmp[63:32] <= tmr_wdata;

            if (csr_we && csr_addr == 12'h304) mie_mtie <= new_val[7];
            if (csr_we && csr_addr == 12'h305) mtvec    <= {new_val[XLEN-1:2], 2'b00};
            if (csr_we && csr_addr == 12'h340) mscratch <= new_val;

            // Trap entry outranks mret, which outranks software writes.
            if (trap_valid) begin
                mepc         <= {trap_pc[XLEN-1:2], 2'b00};
                mcause       <= trap_cause;
                mtval        <= trap_tval;
                mstatus_mpie <= mstatus_mie;
                mstatus_mie  <= 1'b0;
            end else begin
                if (mret) begin
                    mstatus_mie  <= mstatus_mpie;
                    mstatus_mpie <= 1'b1;
                end else if (csr_we && csr_addr == 12'h300) begin
                    mstatus_mie  <= new_val[3];
                    mstatus_mpie <= new_val[7];
                end
                if (csr_we && csr_addr == 12'h341) mepc   <= {new_val[XLEN-1:2], 2'b00};
                if (csr_we && csr_addr == 12'h342) mcause <= new_val;
                if (csr_we && csr_addr == 12'h343) mtval  <= new_val;
            end
        end
    end

    always_comb begin
        case (tmr_sel)
            2'd0:    tmr_rdata = mtime[31:0];
            2'd1:    tmr_rdata = mtime[63:32];
            2'd2:    tmr_rdata = mtimecmp[31:0];
            default: tmr_rdata = mtimecmp[63:32];
        endcase
    end

    assign trap_vector = mtvec;
    assign mepc_out    = mepc;
    assign irq_timer   = mtip && mie_mtie && mstatus_mie;

endmodule

// File: doc/machine_csr_file.md
Name: machine_csr_file

Overview:
- Parametrised machine-mode CSR file: replaces the fixed-register CSR block.
- Implements Zicsr read-modify-write ops (RW/RS/RC) and illegal-access detection.
- Provides 64-bit mcycle/minstret counters, memory-mapped mtime/mtimecmp timer with prescaler, and trap-entry/mret state update.
- Sits beside the execute stage; the core's trap controller consumes `trap_vector`, `mepc_out` and `irq_timer`.

Parameters:
- XLEN, 32, datapath width (only 32 supported).
- HART_ID, 0, value returned by mhartid.
- RESET_VEC, 32'h0000_0000, mtvec reset value.
- MTIME_DIV, 1, clk cycles per mtime increment (≥1).
- MISA_VAL, 32'h4000_0100, value returned by misa (RV32I).

Ports:
- clk  in  1  clock
- resetn  in  1  reset
- csr_valid  in  1  CSR instruction executing this cycle
- csr_op  in  2  00 none, 01 RW, 10 RS (set), 11 RC (clear)
- csr_addr  in  12  CSR address
- csr_wdata  in  XLEN  rs1/uimm operand
- csr_rdata  out  XLEN  old CSR value (combinational)
- csr_illegal  out  1  access illegal (combinational)
- instret_pulse  in  1  one instruction retired
- trap_valid  in  1  take trap this cycle
- trap_cause  in  XLEN  mcause value
- trap_pc  in  XLEN  faulting PC
- trap_tval  in  XLEN  mtval value
- mret  in  1  mret retiring
- tmr_wr  in  1  timer MMIO write strobe
- tmr_sel  in  2  0 mtime lo, 1 mtime hi, 2 mtimecmp lo, 3 mtimecmp hi
- tmr_wdata  in  XLEN  timer write data
- tmr_rdata  out  XLEN  timer word selected by tmr_sel (combinational)
- trap_vector  out  XLEN  mtvec (direct mode)
- mepc_out  out  XLEN  mepc
- irq_timer  out  1  MTIP & mie.MTIE & mstatus.MIE

Behaviour:
- Reset is synchronous and active-low (`resetn`) on clock `clk`. While `resetn` = 0 on a rising edge, all state is cleared as follows:
  - mstatus.MIE = 0, mstatus.MPIE = 0; mie = 0; mtvec = RESET_VEC.
  - mscratch, mepc, mcause, mtval = 0.
  - mcycle, minstret, mtime = 0; mtimecmp = all ones; prescaler = 0.
  - Outputs follow from the above: irq_timer = 0, trap_vector = RESET_VEC, mepc_out = 0.
- Implemented map (any other address is illegal):
  - F11/F12/F13 read 0; F14 reads HART_ID; 301 misa reads MISA_VAL.
  - 300 mstatus: MIE bit3, MPIE bit7, MPP[12:11] reads 2'b11; all other bits read 0.
  - 304 mie: only bit7 MTIE writable.
  - 305 mtvec: bits[1:0] forced 0.
  - 340 mscratch.
  - 341 mepc: bits[1:0] forced 0.
  - 342 mcause, 343 mtval.
  - 344 mip: bit7 MTIP, read-only, = (mtime ≥ mtimecmp) unsigned 64-bit.
  - B00/B80 mcycle lo/hi; B02/B82 minstret lo/hi.
  - C00/C80 cycle, C01/C81 time (mtime), C02/C82 instret: read-only shadows.
- Write intent:
  - op RW, or op RS/RC with csr_wdata ≠ 0.
  - RS/RC with wdata = 0 is a pure read and never illegal on a read-only CSR.
- csr_illegal = csr_valid & (unimplemented address | (addr[11:10] = 2'b11 & write intent)).
  - Illegal access performs no write; csr_rdata is then 0.
- New value: RW → wdata; RS → old | wdata; RC → old & ~wdata. WARL masks are applied afterwards. The write commits at the rising edge; csr_rdata always returns the pre-write value.
- Counters:
  - mcycle increments every cycle; minstret increments on instret_pulse. Both are 64-bit and wrap from all-ones to 0.
  - A CSR write to a counter half in the same cycle wins over the increment.
  - A write to the lo half leaves the hi half untouched (no carry generated that cycle).
- Timer:
  - Prescaler counts 0..MTIME_DIV-1; mtime increments when it wraps.
  - tmr_wr to a mtime half overrides that cycle's increment for that half.
  - mtimecmp writes take effect next cycle; MTIP is combinational from the registers.
- Trap entry (trap_valid):
  - mepc ← trap_pc & ~3; mcause ← trap_cause; mtval ← trap_tval.
  - MPIE ← MIE; MIE ← 0.
- mret: MIE ← MPIE; MPIE ← 1.
- Priority when events coincide: trap_valid > mret > CSR write for mstatus/mepc/mcause/mtval. A simultaneous CSR write to those registers is dropped. Counter and timer updates are independent of trap/mret.

Test Plan:
- Reset: hold resetn=0 two cycles → trap_vector=RESET_VEC, irq_timer=0, read 344 → 0, read B00 → 0 in the first cycle after release.
- Zicsr ops: RW 340 ← 0xA5A5_0000; RS 340 with 0x0000_00FF → rdata 0xA5A5_0000, then reads 0xA5A5_00FF; RC 340 with 0xA500_0000 → reads 0x00A5_00FF.
- WARL masking: RW 305 ← 0x8000_0003 → trap_vector=0x8000_0000; RW 304 ← 0xFFFF_FFFF → reads 0x80.
- Illegal access:
  - RW C00 → csr_illegal=1, no state change.
  - RS C00 with wdata 0 → legal, returns cycle count.
  - Read 0x7C0 → illegal, rdata 0.
- Timer, MTIME_DIV=4:
  - Write mtimecmp={0,5} with mie=0x80, mstatus.MIE=1 → irq_timer rises after exactly 20 clk.
  - Write mtimecmp hi=0xFFFF_FFFF → irq_timer drops next cycle.
- Trap then mret: MIE=1, trap_valid with pc 0x1006, cause 0x8000_0007 → mepc_out=0x1004, MIE=0, MPIE=1. A simultaneous RW 341 is dropped. mret → MIE=1, MPIE=1.
